d_branch_unit: RTL and testbench

- Decode-stage branch resolution unit for the pipelined MIPS core; successor to the single-mode beq/bne comparator.
- Resolves six branch conditions on forwarded register values, parametrised in data width.
- Adds a PC-indexed table of 2-bit saturating counters, looked up in F and trained in D, plus a mispredict flag and saturating branch/mispredict statistics counters.

---
 rtl/d_branch_unit.sv | 86 ++++++++
 tb/tb_d_branch_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/d_branch_unit.sv
// Decode-stage branch resolution: six compare conditions on forwarded operands,
// a PC-indexed table of 2-bit saturating predictors, and branch/mispredict statistics.
module d_branch_unit #(
  parameter int WIDTH = 32,
  parameter int PHT_DEPTH = 64,
  localparam int IDX_W = $clog2(PHT_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic [2:0]       CMPOp,
  input  logic             br_valid,
  input  logic [31:0]      d_pc,
  input  logic             d_pred_taken,
  input  logic [31:0]      f_pc,
  output logic             f_pred_taken,
  output logic             b_jump,
  output logic             mispredict,
  output logic [WIDTH-1:0] br_cnt,
  output logic [WIDTH-1:0] miss_cnt
);

  // br_valid is a one-sided valid with no ready: every cycle it is high retires
  // one branch (train + count); the pipeline drops it while D is stalled.

  logic [1:0]       pht [PHT_DEPTH];
  logic [IDX_W-1:0] idx_d;
  logic [IDX_W-1:0] idx_f;
  logic             legal_op;
  logic             upd;
  logic             rs_zero;
  logic [1:0]       cur_ctr;
  logic [1:0]       nxt_ctr;

  assign idx_d    = d_pc[IDX_W+1:2];
  assign idx_f    = f_pc[IDX_W+1:2];
  assign legal_op = (CMPOp <= 3'd5);
  assign upd      = br_valid & legal_op;
  assign rs_zero  = (rs == '0);

  always_comb begin
    b_jump = 1'b0;
    case (CMPOp)
      3'd0: b_jump = (rs == rt);
      3'd1: b_jump = (rs != rt);
      3'd2: b_jump = rs[WIDTH-1] | rs_zero;
      3'd3: b_jump = ~rs[WIDTH-1] & ~rs_zero;
      3'd4: b_jump = rs[WIDTH-1];
      3'd5: b_jump = ~rs[WIDTH-1];
      default: b_jump = 1'b0;
    endcase
  end

  assign mispredict = upd & (b_jump != d_pred_taken);

  // Saturating move along SNT <-> WNT <-> WT <-> ST
  always_comb begin
    cur_ctr = pht[idx_d];
    nxt_ctr = cur_ctr;
    if (b_jump) begin
      if (cur_ctr != 2'b11) nxt_ctr = cur_ctr + 2'd1;
    end else begin
      if (cur_ctr != 2'b00) nxt_ctr = cur_ctr - 2'd1;
    end
  end

  // Fetch sees the counter it would read next cycle when D writes the same entry
  always_comb begin
    f_pred_taken = pht[idx_f][1];
    if (upd && (idx_f == idx_d)) f_pred_taken = nxt_ctr[1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PHT_DEPTH; i++) pht[i] <= 2'b01;
      br_cnt   <= '0;
      miss_cnt <= '0;
    end else if (upd) begin
      pht[idx_d] <= nxt_ctr;
      if (br_cnt != '1) br_cnt <= br_cnt + WIDTH'(1);
      if (mispredict && (miss_cnt != '1)) miss_cnt <= miss_cnt + WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_d_branch_unit.sv
// Directed bench for d_branch_unit: a 32-bit instance for compare/predict/bypass
// behaviour and a 4-bit instance for statistics and counter saturation.
module tb_d_branch_unit;

  logic clk;
  int   checks;
  int   errors;

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst32;
  logic [31:0] rs32, rt32;
  logic [2:0]  op32;
  logic        bv32, dpred32;
  logic [31:0] dpc32, fpc32;
  logic        fpred32, bj32, mis32;
  logic [31:0] brc32, missc32;

  logic        rst4;
  logic [3:0]  rs4, rt4;
  logic [2:0]  op4;
  logic        bv4, dpred4;
  logic [31:0] dpc4, fpc4;
  logic        fpred4, bj4, mis4;
  logic [3:0]  brc4, missc4;

  d_branch_unit #(.WIDTH(32), .PHT_DEPTH(64)) u32 (
    .clk(clk), .reset(rst32), .rs(rs32), .rt(rt32), .CMPOp(op32),
    .br_valid(bv32), .d_pc(dpc32), .d_pred_taken(dpred32), .f_pc(fpc32),
    .f_pred_taken(fpred32), .b_jump(bj32), .mispredict(mis32),
    .br_cnt(brc32), .miss_cnt(missc32)
  );

  d_branch_unit #(.WIDTH(4), .PHT_DEPTH(64)) u4 (
    .clk(clk), .reset(rst4), .rs(rs4), .rt(rt4), .CMPOp(op4),
    .br_valid(bv4), .d_pc(dpc4), .d_pred_taken(dpred4), .f_pc(fpc4),
    .f_pred_taken(fpred4), .b_jump(bj4), .mispredict(mis4),
    .br_cnt(brc4), .miss_cnt(missc4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst32 = 1'b0; rs32 = '0; rt32 = '0; op32 = 3'd6; bv32 = 1'b0; dpred32 = 1'b0;
    dpc32 = 32'h0; fpc32 = 32'h3000;
    rst4 = 1'b0; rs4 = '0; rt4 = '0; op4 = 3'd6; bv4 = 1'b0; dpred4 = 1'b0;
    dpc4 = 32'h3010; fpc4 = 32'h3010;
    #2;
    chk("reset_fpred", fpred32, 0);
    chk("reset_brcnt", brc32, 0);
    chk("reset_misscnt", missc32, 0);
    tick;
    rst32 = 1'b1;
    rst4  = 1'b1;
    tick;

    // compare conditions (br_valid=0)
    rs32 = 32'hFFFF_FFFF;
    op32 = 3'd2; #1; chk("blez_neg", bj32, 1);
    op32 = 3'd4; #1; chk("bltz_neg", bj32, 1);
    op32 = 3'd3; #1; chk("bgtz_neg", bj32, 0);
    op32 = 3'd5; #1; chk("bgez_neg", bj32, 0);
    rs32 = 32'h0;
    op32 = 3'd2; #1; chk("blez_zero", bj32, 1);
    op32 = 3'd5; #1; chk("bgez_zero", bj32, 1);
    op32 = 3'd3; #1; chk("bgtz_zero", bj32, 0);
    rs32 = 32'h5;
    op32 = 3'd3; #1; chk("bgtz_pos", bj32, 1);
    op32 = 3'd2; #1; chk("blez_pos", bj32, 0);
    rs32 = 32'h1234; rt32 = 32'h1234;
    op32 = 3'd0; #1; chk("beq_eq", bj32, 1);
    op32 = 3'd1; #1; chk("bne_eq", bj32, 0);
    rt32 = 32'h1235;
    op32 = 3'd0; #1; chk("beq_ne", bj32, 0);
    op32 = 3'd1; #1; chk("bne_ne", bj32, 1);
    chk("mis_no_valid", mis32, 0);

    // illegal op with br_valid=1
    rt32 = 32'h1234; op32 = 3'd7; bv32 = 1'b1; dpred32 = 1'b1; dpc32 = 32'h3000;
    #1;
    chk("op7_bjump", bj32, 0);
    chk("op7_mis", mis32, 0);
    tick;
    op32 = 3'd6; #1;
    chk("op6_mis", mis32, 0);
    tick;
    bv32 = 1'b0; #1;
    chk("op7_brcnt", brc32, 0);
    chk("op7_fpred", fpred32, 0);

    // training at 0x3010: three taken beq
    dpc32 = 32'h3010; op32 = 3'd0; bv32 = 1'b1; dpred32 = 1'b0; fpc32 = 32'h3000;
    #1; chk("train1_mis", mis32, 1);
    tick;
    dpred32 = 1'b1; #1; chk("train2_mis", mis32, 0);
    tick;
    #1; chk("train3_mis", mis32, 0);
    tick;
    bv32 = 1'b0; fpc32 = 32'h3010; #1;
    chk("train_st_fpred", fpred32, 1);
    chk("train_brcnt", brc32, 3);
    chk("train_misscnt", missc32, 1);
    // two not-taken (bne on equal operands)
    op32 = 3'd1; bv32 = 1'b1; dpred32 = 1'b1; fpc32 = 32'h3000;
    #1; chk("nt1_mis", mis32, 1);
    tick;
    bv32 = 1'b0; fpc32 = 32'h3010; #1;
    chk("nt1_wt_fpred", fpred32, 1);
    bv32 = 1'b1; fpc32 = 32'h3000; #1;
    chk("nt2_mis", mis32, 1);
    tick;
    bv32 = 1'b0; fpc32 = 32'h3010; #1;
    chk("nt2_wnt_fpred", fpred32, 0);
    chk("nt_brcnt", brc32, 5);
    chk("nt_misscnt", missc32, 3);

    // same-cycle bypass at 0x3020
    dpc32 = 32'h3020; fpc32 = 32'h3020; op32 = 3'd0; dpred32 = 1'b0; #1;
    chk("bypass_before", fpred32, 0);
    bv32 = 1'b1; #1;
    chk("bypass_same_cycle", fpred32, 1);
    tick;
    bv32 = 1'b0; #1;
    chk("bypass_after", fpred32, 1);
    chk("bypass_brcnt", brc32, 6);
    chk("bypass_misscnt", missc32, 4);

    // aliasing: 0x3000 and 0x3100 share index 0
    dpc32 = 32'h3000; fpc32 = 32'h3104; bv32 = 1'b1; dpred32 = 1'b0;
    tick;
    dpred32 = 1'b1;
    tick;
    bv32 = 1'b0; fpc32 = 32'h3100; #1;
    chk("alias_fpred", fpred32, 1);
    fpc32 = 32'h3104; #1;
    chk("alias_neighbor", fpred32, 0);
    chk("alias_brcnt", brc32, 8);
    chk("alias_misscnt", missc32, 5);

    // asynchronous reset mid-cycle
    fpc32 = 32'h3100; rs32 = 32'h7; rt32 = 32'h7; op32 = 3'd0;
    #2;
    rst32 = 1'b0; #1;
    chk("async_brcnt", brc32, 0);
    chk("async_misscnt", missc32, 0);
    chk("async_fpred", fpred32, 0);
    chk("async_bjump", bj32, 1);
    chk("async_mis", mis32, 0);
    tick;
    rst32 = 1'b1;
    tick;

    // WIDTH=4: 20 mispredicted taken branches at 0x3010
    op4 = 3'd0; rs4 = 4'h3; rt4 = 4'h3; dpred4 = 1'b0; bv4 = 1'b1;
    #1; chk("w4_mis", mis4, 1);
    for (int i = 0; i < 10; i++) tick;
    chk("w4_brcnt10", brc4, 4'hA);
    for (int i = 0; i < 10; i++) tick;
    chk("w4_brcnt_sat", brc4, 4'hF);
    chk("w4_misscnt_sat", missc4, 4'hF);
    bv4 = 1'b0; #1;
    chk("w4_st_fpred", fpred4, 1);
    for (int i = 0; i < 3; i++) tick;
    chk("w4_idle_brcnt", brc4, 4'hF);
    chk("w4_idle_fpred", fpred4, 1);
    // two not-taken steps: ST -> WT -> WNT proves the entry did not wrap
    op4 = 3'd1; bv4 = 1'b1; dpred4 = 1'b1;
    tick;
    bv4 = 1'b0; #1;
    chk("w4_wt_fpred", fpred4, 1);
    bv4 = 1'b1;
    tick;
    bv4 = 1'b0; #1;
    chk("w4_wnt_fpred", fpred4, 0);
    chk("w4_final_brcnt", brc4, 4'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
